// File: rtl/line_pkg.sv
// Shared definitions for the pill line plant model: FSM encoding, parameter defaults and
// saturating arithmetic used by the plant and by controller-side benches.
package line_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFeeding = 2'd1,
    StMoving  = 2'd2,
    StJammed  = 2'd3
  } plant_state_e;

  localparam int unsigned PillPeriodDef   = 1000;
  localparam int unsigned PulseWDef       = 50;
  localparam int unsigned SwitchCyclesDef = 1500;
  localparam int unsigned StockInitDef    = 500;
  localparam int unsigned RefillAmtDef    = 100;

  localparam int unsigned CountMax  = 999;
  localparam int unsigned BottleMax = 99;

  function automatic logic [9:0] sat_add_999(input logic [9:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    return (s > CountMax) ? 10'(CountMax) : 10'(s);
  endfunction

endpackage

// File: rtl/pill_pulse_gen.sv
// Pill period counter plus hopper pulse stretcher; emit_o marks the cycle a pill is released,
// pulse_o is the stretched registered pulse that follows it.
module pill_pulse_gen #(
  parameter int unsigned PILL_PERIOD = 10,
  parameter int unsigned PULSE_W     = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic ok_i,
  output logic emit_o,
  output logic pulse_o
);

  localparam int unsigned CntW = (PILL_PERIOD > 1) ? $clog2(PILL_PERIOD) : 1;
  localparam int unsigned RemW = $clog2(PULSE_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(PILL_PERIOD - 1);
  localparam logic [RemW-1:0] RemInit = RemW'(PULSE_W - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RemW-1:0] rem_q, rem_d;
  logic            pulse_q, pulse_d;
  logic            at_last;

  always_comb begin
    at_last = (cnt_q == CntLast);
    emit_o  = enable_i & ok_i & at_last;
    cnt_d   = '0;
    if (enable_i && !at_last) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // A started pulse runs to completion regardless of enable_i.
    pulse_d = pulse_q;
    rem_d   = rem_q;
    if (emit_o) begin
      pulse_d = 1'b1;
      rem_d   = RemInit;
    end else if (rem_q != '0) begin
      rem_d = rem_q - RemW'(1);
    end else begin
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/line_plant_sim.sv
// Behavioural plant for a pill-bottling line: hopper dispensing pills into a bottle, conveyor
// bottle changes with jam injection, and manual hopper refill.
module line_plant_sim
  import line_pkg::*;
#(
  parameter int unsigned PILL_PERIOD   = PillPeriodDef,
  parameter int unsigned PULSE_W       = PulseWDef,
  parameter int unsigned SWITCH_CYCLES = SwitchCyclesDef,
  parameter int unsigned STOCK_INIT    = StockInitDef,
  parameter int unsigned REFILL_AMT    = RefillAmtDef
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       feed_en,
  input  logic       bottle_req,
  input  logic       refill,
  input  logic       inj_stall,
  input  logic       inj_jam,
  output logic       hopper_level,
  output logic       conveyor_signal,
  output logic [9:0] stock,
  output logic [9:0] pills_in_bottle,
  output logic [6:0] bottle_cnt,
  output logic [1:0] plant_state
);

  localparam int unsigned MvW = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
  localparam logic [MvW-1:0] MvLast = MvW'(SWITCH_CYCLES - 1);

  plant_state_e   state_q, state_d;
  logic [MvW-1:0] mv_q, mv_d;
  logic [9:0]     stock_q, stock_d, stock_add;
  logic [9:0]     pills_q, pills_d;
  logic [6:0]     bottle_q, bottle_d;
  logic           refill_q;
  logic           conv_q, conv_d;
  logic           refill_rise;
  logic           complete;
  logic           emit;
  logic           pulse;

  pill_pulse_gen #(
    .PILL_PERIOD (PILL_PERIOD),
    .PULSE_W     (PULSE_W)
  ) u_pulse_gen (
    .clk_i    (clk_1khz),
    .rst_i    (switch_clr),
    .enable_i (state_q == StFeeding),
    .ok_i     ((stock_q != '0) && !inj_stall),
    .emit_o   (emit),
    .pulse_o  (pulse)
  );

  always_comb begin
    state_d  = state_q;
    mv_d     = '0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bottle_req) begin
          state_d = StMoving;
        end else if (feed_en) begin
          state_d = StFeeding;
        end
      end
      StFeeding: begin
        if (bottle_req) begin
          state_d = StMoving;
        end else if (!feed_en) begin
          state_d = StIdle;
        end
      end
      StMoving: begin
        if (mv_q == MvLast) begin
          if (inj_jam) begin
            state_d = StJammed;
          end else begin
            state_d  = StIdle;
            complete = 1'b1;
          end
        end else begin
          mv_d = mv_q + MvW'(1);
        end
      end
      StJammed: begin
        if (!inj_jam) begin
          state_d  = StIdle;
          complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    refill_rise = refill & ~refill_q;
    // Refill saturates first, then the emitted pill is taken out.
    stock_add   = refill_rise ? sat_add_999(stock_q, REFILL_AMT) : stock_q;
    stock_d     = emit ? stock_add - 10'd1 : stock_add;
    pills_d     = pills_q;
    if (complete) begin
      pills_d = '0;
    end else if (emit) begin
      pills_d = sat_add_999(pills_q, 1);
    end
    bottle_d = bottle_q;
    if (complete && (bottle_q < 7'(BottleMax))) begin
      bottle_d = bottle_q + 7'd1;
    end
    conv_d = (state_q == StIdle) || (state_q == StFeeding);
  end

  always_ff @(posedge clk_1khz) begin
    if (switch_clr) begin
      state_q  <= StIdle;
      mv_q     <= '0;
      stock_q  <= 10'(STOCK_INIT);
      pills_q  <= '0;
      bottle_q <= '0;
      refill_q <= 1'b0;
      conv_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mv_q     <= mv_d;
      stock_q  <= stock_d;
      pills_q  <= pills_d;
      bottle_q <= bottle_d;
      refill_q <= refill;
      conv_q   <= conv_d;
    end
  end

  assign hopper_level    = pulse;
  assign conveyor_signal = conv_q;
  assign stock           = stock_q;
  assign pills_in_bottle = pills_q;
  assign bottle_cnt      = bottle_q;
  assign plant_state     = state_q;

endmodule
